mem_access_unit: RTL and testbench

//  Initiator for the data memory unit (isLd/isSt/address/data_in/data_out): memory-access stage.

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 108 ++++++++++
 tb/tb_mem_access_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX request, data-memory port and RW result bundle for mem_access_unit.
interface mem_access_unit_if #(parameter int RD_W = 4);
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_isLd;
  logic            ex_isSt;
  logic [31:0]     ex_addr;
  logic [31:0]     ex_data;
  logic [RD_W-1:0] ex_rd;
  logic            mem_isLd;
  logic            mem_isSt;
  logic [31:0]     mem_address;
  logic [31:0]     mem_data_in;
  logic [31:0]     mem_data_out;
  logic            rw_valid;
  logic            rw_ready;
  logic [31:0]     rw_data;
  logic [RD_W-1:0] rw_rd;
  logic            addr_err;
  modport slave (
    input  ex_valid, ex_isLd, ex_isSt, ex_addr, ex_data, ex_rd, mem_data_out, rw_ready,
    output ex_ready, mem_isLd, mem_isSt, mem_address, mem_data_in, rw_valid, rw_data, rw_rd, addr_err
  );
  modport master (
    output ex_valid, ex_isLd, ex_isSt, ex_addr, ex_data, ex_rd, mem_data_out, rw_ready,
    input  ex_ready, mem_isLd, mem_isSt, mem_address, mem_data_in, rw_valid, rw_data, rw_rd, addr_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage, one load/store/pass-through op at a time, MEM_LAT-cycle memory hold.
// Define MEM_BOUNDS_CHECK_EN to suppress and flag accesses with ex_addr >= MEM_DEPTH.
module mem_access_unit #(
  parameter int MEM_DEPTH = 26,
  parameter int MEM_LAT   = 1,
  parameter int RD_W      = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHECK = 1'b1;
`else
  localparam bit BOUNDS_CHECK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ld;
  logic            r_oob;
  logic            r_mem_ld;
  logic            r_mem_st;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_rw_valid;
  logic [31:0]     r_rw_data;
  logic [RD_W-1:0] r_rd;
  logic            r_addr_err;
  logic            w_oob;
  assign w_oob           = BOUNDS_CHECK && (bus.ex_addr >= 32'(MEM_DEPTH));
  assign bus.ex_ready    = (r_state == IDLE);
  assign bus.mem_isLd    = r_mem_ld;
  assign bus.mem_isSt    = r_mem_st;
  assign bus.mem_address = r_addr;
  assign bus.mem_data_in = r_wdata;
  assign bus.rw_valid    = r_rw_valid;
  assign bus.rw_data     = r_rw_data;
  assign bus.rw_rd       = r_rd;
  assign bus.addr_err    = r_addr_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ld       <= 1'b0;
      r_oob      <= 1'b0;
      r_mem_ld   <= 1'b0;
      r_mem_st   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rw_valid <= 1'b0;
      r_rw_data  <= '0;
      r_rd       <= '0;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr_err <= 1'b0;
          if (bus.ex_valid) begin
            r_rd  <= bus.ex_rd;
            r_cnt <= '0;
            // exactly one of isLd/isSt is a memory op; neither or both pass ex_data straight through
            if (bus.ex_isLd ^ bus.ex_isSt) begin
              r_state    <= ACCESS;
              r_ld       <= bus.ex_isLd;
              r_oob      <= w_oob;
              r_addr     <= bus.ex_addr;
              r_wdata    <= bus.ex_data;
              r_mem_ld   <= bus.ex_isLd & ~w_oob;
              r_mem_st   <= bus.ex_isSt & ~w_oob;
              r_addr_err <= bus.ex_isSt & w_oob;
            end else begin
              r_state    <= RESP;
              r_rw_valid <= 1'b1;
              r_rw_data  <= bus.ex_data;
            end
          end
        end
        ACCESS: begin
          r_addr_err <= 1'b0;
          if (r_cnt == CW'(MEM_LAT - 1)) begin
            r_mem_ld <= 1'b0;
            r_mem_st <= 1'b0;
            if (r_ld) begin
              r_state    <= RESP;
              r_rw_valid <= 1'b1;
              r_rw_data  <= r_oob ? 32'd0 : bus.mem_data_out;
              r_addr_err <= r_oob;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rw_ready) begin
            r_state    <= IDLE;
            r_rw_valid <= 1'b0;
            r_addr_err <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: vector table plus latency/backpressure/reset sequences, results checked via scoreboard.
module tb_mem_access_unit;
  localparam int LAT   = 3;
  localparam int DEPTH = 26;
  localparam int RDW   = 4;
`ifdef MEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  typedef struct {
    logic            ld;
    logic            st;
    logic [31:0]     addr;
    logic [31:0]     data;
    logic [RDW-1:0]  rd;
    logic            resp;
    logic [31:0]     exp;
    logic            err;
    int              mcyc;
  } vec_t;
  typedef struct {
    logic [31:0]    d;
    logic [RDW-1:0] rd;
    logic           e;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_access_unit_if #(.RD_W(RDW)) bus ();
  mem_access_unit #(.MEM_DEPTH(DEPTH), .MEM_LAT(LAT), .RD_W(RDW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  logic [31:0] mem_arr [64];
  always @(posedge clk) if (bus.mem_isSt) mem_arr[bus.mem_address[5:0]] <= bus.mem_data_in;
  assign bus.mem_data_out = bus.mem_isLd ? mem_arr[bus.mem_address[5:0]] : 32'h0;
  int checks = 0;
  int errors = 0;
  int ld_cyc, st_cyc, err_cyc, rw_cyc;
  logic [31:0] cur_addr, cur_data;
  exp_t sb[$];
  vec_t vecs[12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.mem_isLd) ld_cyc++;
      if (bus.mem_isSt) st_cyc++;
      if (bus.addr_err) err_cyc++;
      if (bus.rw_valid) rw_cyc++;
      if (bus.mem_isLd || bus.mem_isSt) chk("mem_address", bus.mem_address, cur_addr);
      if (bus.mem_isSt) chk("mem_data_in", bus.mem_data_in, cur_data);
      if (bus.rw_valid && bus.rw_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rw_unexpected: got result 0x%0h expected no result", bus.rw_data);
        end else begin
          e = sb.pop_front();
          chk("rw_data", bus.rw_data, e.d);
          chk("rw_rd", 32'(bus.rw_rd), 32'(e.rd));
          chk("rw_addr_err", 32'(bus.addr_err), 32'(e.e));
        end
      end
    end
  endtask
  task automatic wait_ready(input string n);
    int k = 0;
    while (!bus.ex_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(n, 32'(bus.ex_ready), 32'd1);
  endtask
  task automatic run_op(input vec_t v);
    wait_ready("ready_before_op");
    ld_cyc   = 0;
    st_cyc   = 0;
    err_cyc  = 0;
    cur_addr = v.addr;
    cur_data = v.data;
    bus.ex_valid = 1'b1;
    bus.ex_isLd  = v.ld;
    bus.ex_isSt  = v.st;
    bus.ex_addr  = v.addr;
    bus.ex_data  = v.data;
    bus.ex_rd    = v.rd;
    if (v.resp) sb.push_back('{v.exp, v.rd, v.err});
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    wait_ready("op_done");
    chk("ld_cycles", 32'(ld_cyc), (v.ld && !v.st) ? 32'(v.mcyc) : 32'd0);
    chk("st_cycles", 32'(st_cyc), (v.st && !v.ld) ? 32'(v.mcyc) : 32'd0);
    chk("err_cycles", 32'(err_cyc), v.err ? 32'd1 : 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    vecs[0]  = '{1'b0, 1'b1, 32'd5,  32'hAB,       4'd1,  1'b0, 32'h0,        1'b0, LAT};
    vecs[1]  = '{1'b1, 1'b0, 32'd5,  32'h0,        4'd3,  1'b1, 32'hAB,       1'b0, LAT};
    vecs[2]  = '{1'b0, 1'b0, 32'd0,  32'h1234,     4'd7,  1'b1, 32'h1234,     1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 32'd6,  32'h55AA,     4'd2,  1'b1, 32'h55AA,     1'b0, 0};
    vecs[4]  = '{1'b0, 1'b1, 32'd25, 32'hDEADBEEF, 4'd0,  1'b0, 32'h0,        1'b0, LAT};
    vecs[5]  = '{1'b0, 1'b1, 32'd0,  32'h1,        4'd0,  1'b0, 32'h0,        1'b0, LAT};
    vecs[6]  = '{1'b1, 1'b0, 32'd25, 32'h0,        4'd15, 1'b1, 32'hDEADBEEF, 1'b0, LAT};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,  32'h0,        4'd4,  1'b1, 32'h1,        1'b0, LAT};
    vecs[8]  = '{1'b0, 1'b1, 32'd5,  32'hCAFE,     4'd0,  1'b0, 32'h0,        1'b0, LAT};
    vecs[9]  = '{1'b0, 1'b1, 32'd30, 32'h77,       4'd0,  1'b0, 32'h0,        BC,   BC ? 0 : LAT};
    vecs[10] = '{1'b1, 1'b0, 32'd30, 32'h0,        4'd9,  1'b1, BC ? 32'h0 : 32'h77, BC, BC ? 0 : LAT};
    vecs[11] = '{1'b1, 1'b0, 32'd5,  32'h0,        4'd10, 1'b1, 32'hCAFE,     1'b0, LAT};
    bus.ex_valid = 1'b0;
    bus.ex_isLd  = 1'b0;
    bus.ex_isSt  = 1'b0;
    bus.ex_addr  = '0;
    bus.ex_data  = '0;
    bus.ex_rd    = '0;
    bus.rw_ready = 1'b1;
    cur_addr = '0;
    cur_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ex_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_rw_valid", 32'(bus.rw_valid), 32'd0);
    chk("rst_mem_isLd", 32'(bus.mem_isLd), 32'd0);
    chk("rst_mem_isSt", 32'(bus.mem_isSt), 32'd0);
    chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
    chk("rst_rw_data", bus.rw_data, 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);
    rst_n = 1'b1;
    fork
      monitor();
    join_none
    for (int i = 0; i < 12; i++) run_op(vecs[i]);
    // load held in RESP by rw_ready=0 while a second op waits on ex_valid
    wait_ready("ready_before_lat");
    bus.rw_ready = 1'b0;
    cur_addr     = 32'd5;
    bus.ex_valid = 1'b1;
    bus.ex_isLd  = 1'b1;
    bus.ex_isSt  = 1'b0;
    bus.ex_addr  = 32'd5;
    bus.ex_rd    = 4'd6;
    sb.push_back('{32'hCAFE, 4'd6, 1'b0});
    @(posedge clk);
    #1;
    bus.ex_isLd = 1'b0;
    bus.ex_data = 32'h999;
    bus.ex_rd   = 4'd8;
    for (int j = 1; j <= LAT + 5; j++) begin
      @(negedge clk);
      chk("lat_ex_ready", 32'(bus.ex_ready), 32'd0);
      chk("lat_rw_valid", 32'(bus.rw_valid), (j >= LAT + 1) ? 32'd1 : 32'd0);
      chk("lat_mem_isLd", 32'(bus.mem_isLd), (j <= LAT) ? 32'd1 : 32'd0);
      if (j >= LAT + 1) chk("hold_rw_data", bus.rw_data, 32'hCAFE);
    end
    @(posedge clk);
    #1;
    sb.push_back('{32'h999, 4'd8, 1'b0});
    bus.rw_ready = 1'b1;
    wait_ready("ready_after_bp");
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    chk("second_accepted", 32'(bus.ex_ready), 32'd0);
    wait_ready("second_done");
    // reset while a store is in ACCESS
    cur_addr     = 32'd9;
    cur_data     = 32'h33;
    bus.ex_valid = 1'b1;
    bus.ex_isLd  = 1'b0;
    bus.ex_isSt  = 1'b1;
    bus.ex_addr  = 32'd9;
    bus.ex_data  = 32'h33;
    bus.ex_rd    = 4'd1;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_isSt_before", 32'(bus.mem_isSt), 32'd1);
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    rw_cyc = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_isSt", 32'(bus.mem_isSt), 32'd0);
    chk("rst_mid_ready", 32'(bus.ex_ready), 32'd1);
    chk("rst_mid_rw_valid", 32'(bus.rw_valid), 32'd0);
    rst_n = 1'b1;
    k = 0;
    repeat (6) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("rst_mid_no_result", 32'(rw_cyc), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
